// File: rtl/ct_lsu_spsram_512x7_arb.sv
// Front-end for a single-port 512x7 LSU SRAM: clears every entry after reset, then
// arbitrates one access per cycle between a write and a read requester.
module ct_lsu_spsram_512x7_arb #(
  parameter int unsigned             ADDR_WIDTH = 9,
  parameter int unsigned             DATA_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0]   INIT_VAL   = '0,
  parameter int unsigned             STARVE_MAX = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_grnt,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_grnt,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int unsigned      CNT_WIDTH  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] STARVE_LIM = CNT_WIDTH'(STARVE_MAX);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  init_done_q, init_done_d;
  logic [CNT_WIDTH-1:0]  starve_q, starve_d;
  logic                  rd_data_vld_q, rd_data_vld_d;
  logic                  force_rd;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    starve_d    = starve_q;
    force_rd    = (starve_q == STARVE_LIM) && rd_vld;
    wr_grnt     = 1'b0;
    rd_grnt     = 1'b0;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_a      = '0;
    sram_d      = '0;

    // Grants and the chip enable are gated by reset so nothing reaches the SRAM
    // while cpurst_b is low.
    if (cpurst_b) begin
      unique case (state_q)
        ST_INIT: begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = ptr_q;
          sram_d    = INIT_VAL;
          ptr_d     = ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end
        end
        ST_IDLE: begin
          wr_grnt = wr_vld && !force_rd;
          rd_grnt = rd_vld && (!wr_vld || force_rd);
          if (wr_grnt) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_mask;
            sram_a    = wr_addr;
            sram_d    = wr_data;
          end else if (rd_grnt) begin
            sram_cen  = 1'b0;
            sram_a    = rd_addr;
          end

          if (!rd_vld || rd_grnt) begin
            starve_d = '0;
          end else if (wr_grnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
          end

          if (init_req) begin
            state_d     = ST_INIT;
            init_done_d = 1'b0;
            ptr_d       = '0;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign rd_data_vld_d = rd_grnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q       <= ST_INIT;
      ptr_q         <= '0;
      init_done_q   <= 1'b0;
      starve_q      <= '0;
      rd_data_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      init_done_q   <= init_done_d;
      starve_q      <= starve_d;
      rd_data_vld_q <= rd_data_vld_d;
    end
  end

  assign init_done   = init_done_q;
  assign rd_data_vld = rd_data_vld_q;
  assign rd_data     = rd_data_vld_q ? sram_q : '0;

endmodule

// File: tb/tb_ct_lsu_spsram_512x7_arb.sv
// Directed bench for ct_lsu_spsram_512x7_arb with a behavioural 512x7 bit-masked SRAM.
module tb_ct_lsu_spsram_512x7_arb;

  logic       forever_cpuclk;
  logic       cpurst_b;
  logic       init_req;
  logic       init_done;
  logic       wr_vld;
  logic [8:0] wr_addr;
  logic [6:0] wr_data;
  logic [6:0] wr_mask;
  logic       wr_grnt;
  logic       rd_vld;
  logic [8:0] rd_addr;
  logic       rd_grnt;
  logic       rd_data_vld;
  logic [6:0] rd_data;
  logic [8:0] sram_a;
  logic       sram_cen;
  logic       sram_gwen;
  logic [6:0] sram_wen;
  logic [6:0] sram_d;
  logic [6:0] sram_q;

  int checks   = 0;
  int failures = 0;

  ct_lsu_spsram_512x7_arb dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .init_req       (init_req),
    .init_done      (init_done),
    .wr_vld         (wr_vld),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_grnt        (wr_grnt),
    .rd_vld         (rd_vld),
    .rd_addr        (rd_addr),
    .rd_grnt        (rd_grnt),
    .rd_data_vld    (rd_data_vld),
    .rd_data        (rd_data),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  // SRAM model, preloaded with a non-zero pattern so a missing clear is visible.
  logic [6:0] mem [512];
  initial begin
    sram_q = 7'h00;
    for (int i = 0; i < 512; i++) mem[i] = 7'h33;
  end
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mem[sram_a];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  // Follows a sweep from its first cycle; pulses init_req at sweep cycle pulse_at.
  task automatic run_sweep(input string tag, input int pulse_at);
    int n   = 0;
    int bad = 0;
    while (init_done !== 1'b1 && n < 1000) begin
      init_req = (n == pulse_at);
      #1;
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 7'h00 ||
          sram_a !== n[8:0] || sram_d !== 7'h00 || wr_grnt !== 1'b0 || rd_grnt !== 1'b0)
        bad++;
      step();
      n++;
    end
    init_req = 1'b0;
    check({tag, "_len"}, n, 512);
    check({tag, "_bad"}, bad, 0);
  endtask

  task automatic do_write(input string tag, input logic [8:0] a, input logic [6:0] d,
                          input logic [6:0] m);
    int n = 0;
    wr_vld = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    #1;
    while (wr_grnt !== 1'b1 && n < 20) begin step(); n++; end
    check({tag, "_grnt"}, wr_grnt, 1);
    check({tag, "_port"}, {sram_cen, sram_gwen, sram_a, sram_d, sram_wen},
          {1'b0, 1'b0, a, d, ~m});
    step();
    wr_vld = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [8:0] a, input logic [6:0] exp);
    int n = 0;
    rd_vld = 1'b1; rd_addr = a;
    #1;
    while (rd_grnt !== 1'b1 && n < 20) begin step(); n++; end
    check({tag, "_grnt"}, rd_grnt, 1);
    check({tag, "_port"}, {sram_cen, sram_gwen, sram_a, sram_wen}, {1'b0, 1'b1, a, 7'h7F});
    step();
    rd_vld = 1'b0;
    #1;
    check({tag, "_ret"}, {rd_data_vld, rd_data}, {1'b1, exp});
  endtask

  logic [15:0] pw, pr, pv;
  logic [6:0]  rq;
  logic        pend, both;

  initial begin
    cpurst_b = 1'b0; init_req = 1'b0;
    wr_vld = 1'b1; wr_addr = 9'h000; wr_data = 7'h00; wr_mask = 7'h7F;
    rd_vld = 1'b1; rd_addr = 9'h000;

    // Reset: everything gated even with both requesters asserting.
    repeat (3) step();
    #1;
    check("rst_gate", {sram_cen, wr_grnt, rd_grnt}, 3'b100);
    check("rst_regs", {init_done, rd_data_vld}, 2'b00);
    wr_vld = 1'b0; rd_vld = 1'b0;
    cpurst_b = 1'b1;
    run_sweep("sweep0", -1);
    check("init_done", init_done, 1);

    // Full-mask write followed by a read of the same address.
    do_write("w1a5", 9'h1A5, 7'h55, 7'h7F);
    do_read("r1a5", 9'h1A5, 7'h55);
    step();
    #1;
    check("rd_idle_zero", {rd_data_vld, rd_data}, 8'h00);

    // Partial mask: only the low nibble is overwritten.
    do_write("w010a", 9'h010, 7'h7F, 7'h7F);
    do_write("w010b", 9'h010, 7'h00, 7'h0F);
    do_read("r010", 9'h010, 7'h70);

    // Starvation guard: four writes, forced read, writes resume, guard restarts from 0.
    step();
    wr_vld = 1'b1; wr_addr = 9'h020; wr_data = 7'h01; wr_mask = 7'h7F;
    rd_addr = 9'h021; pend = 1'b1; both = 1'b0; rq = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) pend = 1'b1;
      rd_vld = pend;
      #1;
      pw[i] = wr_grnt; pr[i] = rd_grnt; pv[i] = rd_data_vld;
      both  = both | (wr_grnt & rd_grnt);
      if (rd_data_vld) rq = rd_data;
      if (rd_grnt) pend = 1'b0;
      step();
    end
    wr_vld = 1'b0; rd_vld = 1'b0;
    check("starve_wr", pw, 16'hEFEF);
    check("starve_rd", pr, 16'h1010);
    check("starve_vld", pv, 16'h2020);
    check("starve_onehot", both, 0);
    check("starve_rdata", rq, 7'h00);

    // Same-cycle write and read to one address: write first, read sees new data.
    step();
    wr_vld = 1'b1; wr_addr = 9'h0FF; wr_data = 7'h2A; wr_mask = 7'h7F;
    rd_vld = 1'b1; rd_addr = 9'h0FF;
    #1;
    check("haz_c0", {wr_grnt, rd_grnt}, 2'b10);
    step();
    wr_vld = 1'b0;
    #1;
    check("haz_c1", {wr_grnt, rd_grnt}, 2'b01);
    step();
    rd_vld = 1'b0;
    #1;
    check("haz_ret", {rd_data_vld, rd_data}, {1'b1, 7'h2A});

    // init_req with a concurrent read: the read still returns, then a full re-sweep.
    step();
    init_req = 1'b1; rd_vld = 1'b1; rd_addr = 9'h1A5;
    #1;
    check("ireq_rgrnt", rd_grnt, 1);
    step();
    init_req = 1'b0;
    #1;
    check("ireq_ret", {init_done, rd_data_vld, rd_data}, {1'b0, 1'b1, 7'h55});
    wr_vld = 1'b1; wr_addr = 9'h1A5; wr_data = 7'h11; wr_mask = 7'h7F;
    rd_vld = 1'b1;
    run_sweep("sweep1", 100);
    wr_vld = 1'b0; rd_vld = 1'b0;
    do_read("clr1a5", 9'h1A5, 7'h00);
    do_read("clr010", 9'h010, 7'h00);
    do_read("clr0ff", 9'h0FF, 7'h00);

    // Reset in IDLE with a read pending: no grant, no return, sweep from 0.
    step();
    cpurst_b = 1'b0; rd_vld = 1'b1; rd_addr = 9'h020;
    #1;
    check("rst_idle_gate", {sram_cen, rd_grnt}, 2'b10);
    step();
    cpurst_b = 1'b1; rd_vld = 1'b0;
    #1;
    check("rst_idle_drop", {init_done, rd_data_vld}, 2'b00);
    run_sweep("sweep2", -1);

    // Reset at sweep cycle 200 restarts the sweep at address 0.
    init_req = 1'b1;
    #1;
    step();
    init_req = 1'b0;
    repeat (200) step();
    #1;
    check("mid_a200", sram_a, 9'd200);
    cpurst_b = 1'b0;
    #1;
    check("mid_rst_cen", sram_cen, 1);
    step();
    cpurst_b = 1'b1;
    run_sweep("sweep3", -1);
    do_read("clr020", 9'h020, 7'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
